fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding/hazard control for the 5-stage pipelined CPU.
- Sits directly upstream of the EX-stage 4-to-1 operand muxes and drives their 2-bit selects.
- Keeps its own ID→EX→MEM→WB shadow pipeline of destination info. From that it generates per-operand forward selects and a load-use stall, and counts stall cycles.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  REG_AW  ID source register A.
- id_rt_i  in  REG_AW  ID source register B.
- id_rs_used_i  in  1  instruction reads rs.
- id_rt_used_i  in  1  instruction reads rt.
- id_rd_i  in  REG_AW  ID destination register (already resolved rt/rd/31).
- id_regwrite_i  in  1  instruction writes the register file.
- id_memread_i  in  1  instruction is a load.
- flush_i  in  1  kill ID instruction (taken branch/jump).
- fwd_a_sel_o  out  2  select for operand-A mux.
- fwd_b_sel_o  out  2  select for operand-B mux.
- stall_o  out  1  hold PC and IF/ID; insert bubble into EX.
- stall_cnt_o  out  CNT_W  total stall cycles, saturating.

Behaviour:
- Shadow stages: EX, MEM and WB each hold {valid, rs, rt, rs_used, rt_used, rd, regwrite, memread}. All advance every clock; there is no global freeze input.
- EX entry load:
  - Loaded from the ID inputs with valid = id_valid_i & ~stall_o & ~flush_i.
  - When stall_o=1 or flush_i=1, a bubble is loaded (valid=0, regwrite=0, memread=0).
- MEM ← EX and WB ← MEM unconditionally.
- "Writer" definition: a stage is a writer iff valid & regwrite & rd≠0. Register $0 never forwards and never stalls.
- fwd_a_sel_o (combinational from registered state, zero added latency):
  - 2'd1 if EX.rs_used and MEM is a writer with MEM.rd==EX.rs.
  - else 2'd2 if WB is a writer with WB.rd==EX.rs.
  - else 2'd0.
  - MEM has priority over WB when both match.
- fwd_b_sel_o: same rules using EX.rt and EX.rt_used.
- Select encoding: 0 = ID/EX register data, 1 = EX/MEM ALU result, 2 = MEM/WB write-back data. Code 3 is reserved and never driven.
- If the EX entry is a bubble, both selects are 0.
- Register file is write-first. An instruction three stages ahead needs no forwarding.
- stall_o (combinational) = id_valid_i & ~flush_i & EX.valid & EX.memread & EX.rd≠0 & ((id_rs_used_i & id_rs_i==EX.rd) | (id_rt_used_i & id_rt_i==EX.rd)).
  - A load-use stall lasts exactly 1 cycle. The next cycle EX holds the bubble and MEM holds the load, so forwarding resolves through select 2.
- Simultaneous flush_i and hazard: flush wins, stall_o=0, bubble inserted.
- stall_cnt_o increments on each clock edge where stall_o=1 and holds at all-ones once reached.
- Reset, on rst_i=1 at a rising edge, whether or not operations are in flight:
  - all shadow valid/regwrite/memread bits cleared;
  - stall_cnt_o=0, fwd_a_sel_o=0, fwd_b_sel_o=0, stall_o=0 from the following cycle;
  - any stall in progress is abandoned.
- Outputs never go X after reset, for any input combination.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_REG=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2;
  - REG_AW;
  - a stage-info struct/typedef {valid, rs, rt, rs_used, rt_used, rd, regwrite, memread}, reused by the pipeline registers.
- One natural sub-module: fwd_sel_gen. It is combinational, takes the EX source reg/used plus the MEM/WB writer info, and outputs 2-bit selects. It is instantiated twice, once per operand.

Test Plan:
- Reset: rst_i=1 for 2 cycles with random inputs → selects=0, stall_o=0, stall_cnt_o=0.
- EX→EX forward: add $3 then sub $5,$3,$4 back-to-back → when sub is in EX, fwd_a_sel_o=1 and fwd_b_sel_o=0.
- MEM/WB forward and priority:
  - add $3; nop; or $6,$3,$3 → both selects=2.
  - add $3; add $3; and $7,$3,$0 → fwd_a_sel_o=1 (MEM priority), fwd_b_sel_o=0.
- Load-use: lw $2; add $4,$2,$1 → stall_o=1 for exactly 1 cycle, then fwd_a_sel_o=2, stall_cnt_o=1. Back-to-back loads (lw $2; lw $2; add $4,$2,$1) → stall again, stall_cnt_o=2.
- $0 and flush:
  - lw $0; add $4,$0,$0 → no stall, selects=0.
  - lw $2 with flush_i=1 on a dependent add in ID → stall_o=0 and EX bubble.
- Saturation and mid-op reset:
  - preload counter to all-ones-1, force 3 stalls → counter holds 0xFFFF.
  - assert rst_i during a stall → stall_o=0 and counter=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes and the per-stage
// destination/source record carried by the forwarding shadow pipeline.
package cpu_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,  // ID/EX register data
    FWD_MEM = 2'd1,  // EX/MEM ALU result
    FWD_WB  = 2'd2   // MEM/WB write-back data
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

  // $0 is hard-wired, so a stage aimed at it never produces a usable result.
  function automatic logic is_writer(input stage_info_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Operand forward-select for one EX source register; the younger MEM producer
// wins over WB when both target the same register.
module fwd_sel_gen
  import cpu_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              src_used_i,
  input  logic              mem_wr_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_wr_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    // NOTE: default first so every path assigns sel_o and no latch is inferred.
    sel_o = FWD_REG;
    if (ex_valid_i && src_used_i) begin
      if (mem_wr_i && (mem_rd_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_wr_i && (wb_rd_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control: shadows EX/MEM/WB destination info,
// drives the EX operand-mux selects, stalls on load-use and counts stalls.
module fwd_hazard_ctrl #(
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stage_info_t      ex_q, ex_d;
  stage_info_t      mem_q, mem_d;
  stage_info_t      wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  // A load in EX cannot feed the instruction in ID; a flush kills that consumer.
  assign stall = id_valid_i && !flush_i && ex_q.valid && ex_q.memread &&
                 (ex_q.rd != '0) &&
                 ((id_rs_used_i && (id_rs_i == ex_q.rd)) ||
                  (id_rt_used_i && (id_rt_i == ex_q.rd)));

  always_comb begin
    ex_d          = STAGE_BUBBLE;
    ex_d.valid    = id_valid_i && !stall && !flush_i;
    ex_d.rs       = id_rs_i;
    ex_d.rt       = id_rt_i;
    ex_d.rs_used  = id_rs_used_i;
    ex_d.rt_used  = id_rt_used_i;
    ex_d.rd       = id_rd_i;
    ex_d.regwrite = ex_d.valid && id_regwrite_i;
    ex_d.memread  = ex_d.valid && id_memread_i;

    mem_d = ex_q;
    wb_d  = mem_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: whole stages reset to bubbles so no stale field can reach a compare.
      ex_q        <= STAGE_BUBBLE;
      mem_q       <= STAGE_BUBBLE;
      wb_q        <= STAGE_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  fwd_sel_gen u_fwd_a (
    .ex_valid_i (ex_q.valid),
    .src_i      (ex_q.rs),
    .src_used_i (ex_q.rs_used),
    .mem_wr_i   (is_writer(mem_q)),
    .mem_rd_i   (mem_q.rd),
    .wb_wr_i    (is_writer(wb_q)),
    .wb_rd_i    (wb_q.rd),
    .sel_o      (fwd_a_sel_o)
  );

  fwd_sel_gen u_fwd_b (
    .ex_valid_i (ex_q.valid),
    .src_i      (ex_q.rt),
    .src_used_i (ex_q.rt_used),
    .mem_wr_i   (is_writer(mem_q)),
    .mem_rd_i   (mem_q.rd),
    .wb_wr_i    (is_writer(wb_q)),
    .wb_rd_i    (wb_q.rd),
    .sel_o      (fwd_b_sel_o)
  );

  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed hazard scenarios plus a
// randomized instruction stream compared against an issued-instruction history model.
module tb_fwd_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs_i = '0;
  logic [4:0] id_rt_i = '0;
  logic       id_rs_used_i = 1'b0;
  logic       id_rt_used_i = 1'b0;
  logic [4:0] id_rd_i = '0;
  logic       id_regwrite_i = 1'b0;
  logic       id_memread_i = 1'b0;
  logic       flush_i = 1'b0;

  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;
  logic [1:0]  sat_a_sel, sat_b_sel;
  logic        sat_stall;
  logic [3:0]  sat_cnt;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow-counter instance sharing the stimulus, to reach saturation quickly.
  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .fwd_a_sel_o(sat_a_sel), .fwd_b_sel_o(sat_b_sel),
    .stall_o(sat_stall), .stall_cnt_o(sat_cnt)
  );

  typedef struct {
    bit valid; int rs; int rt; bit rs_used; bit rt_used; int rd; bit regwrite; bit memread;
  } instr_t;

  localparam instr_t BUBBLE = '{default: 0};

  instr_t hist[3];   // instructions accepted into EX: [0]=EX, [1]=MEM, [2]=WB
  int     stall_total;
  int     n_checks;
  int     n_errors;

  function automatic bit writes_reg(input instr_t i);
    return i.valid && i.regwrite && (i.rd != 0);
  endfunction

  function automatic int exp_sel(input int src, input bit used);
    if (!hist[0].valid || !used) return 0;
    if (writes_reg(hist[1]) && hist[1].rd == src) return 1;
    if (writes_reg(hist[2]) && hist[2].rd == src) return 2;
    return 0;
  endfunction

  function automatic bit exp_stall();
    instr_t ld = hist[0];
    if (!id_valid_i || flush_i) return 0;
    if (!(ld.valid && ld.memread && ld.rd != 0)) return 0;
    return (id_rs_used_i && int'(id_rs_i) == ld.rd) || (id_rt_used_i && int'(id_rt_i) == ld.rd);
  endfunction

  function automatic int sat_to(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic tick();
    bit     st = exp_stall();
    instr_t nxt;
    @(posedge clk_i);
    if (rst_i) begin
      hist[0] = BUBBLE; hist[1] = BUBBLE; hist[2] = BUBBLE;
      stall_total = 0;
    end else begin
      if (st) stall_total++;
      nxt = BUBBLE;
      if (id_valid_i && !st && !flush_i) begin
        nxt = '{1, int'(id_rs_i), int'(id_rt_i), id_rs_used_i, id_rt_used_i,
                int'(id_rd_i), id_regwrite_i, id_memread_i};
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input int rd, input bit rw, input bit mr, input bit fl);
    id_valid_i = v; id_rs_i = 5'(rs); id_rt_i = 5'(rt);
    id_rs_used_i = rsu; id_rt_used_i = rtu; id_rd_i = 5'(rd);
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
  endtask

  task automatic op_alu(input int rd, input int rs, input int rt);
    drive(1, rs, rt, 1, 1, rd, 1, 0, 0);
  endtask

  task automatic op_lw(input int rd, input int base);
    drive(1, base, rd, 1, 0, rd, 1, 1, 0);
  endtask

  task automatic op_nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    op_nop();
    repeat (3) tick();
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst_i = 1'b1;
      drive_random();
      tick();
      drive_random();
      #1;
      n_checks++; if (fwd_a_sel_o !== 2'd0) begin n_errors++; $display("FAIL reset_a: got %0d want 0", fwd_a_sel_o); end
      n_checks++; if (fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL reset_b: got %0d want 0", fwd_b_sel_o); end
      n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
      n_checks++; if (stall_cnt_o !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
      n_checks++; if (sat_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
    end
    op_nop();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_ex_fwd();
    drain();
    op_alu(3, 1, 2); tick();
    op_alu(5, 3, 4); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL ex_fwd_nostall: got %0b want 0", stall_o); end
    tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd1) begin n_errors++; $display("FAIL ex_fwd_a: got %0d want 1", fwd_a_sel_o); end
    n_checks++; if (fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL ex_fwd_b: got %0d want 0", fwd_b_sel_o); end
  endtask

  task automatic test_mem_wb();
    drain();
    op_alu(3, 1, 2); tick();
    op_nop(); tick();
    op_alu(6, 3, 3); tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd2) begin n_errors++; $display("FAIL wb_fwd_a: got %0d want 2", fwd_a_sel_o); end
    n_checks++; if (fwd_b_sel_o !== 2'd2) begin n_errors++; $display("FAIL wb_fwd_b: got %0d want 2", fwd_b_sel_o); end

    drain();
    op_alu(3, 1, 2); tick();
    op_alu(3, 1, 2); tick();
    op_alu(7, 3, 0); tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd1) begin n_errors++; $display("FAIL prio_a: got %0d want 1", fwd_a_sel_o); end
    n_checks++; if (fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL prio_b_r0: got %0d want 0", fwd_b_sel_o); end

    // Producer three slots ahead has already written the register file.
    drain();
    op_alu(3, 1, 2); tick();
    op_nop(); tick(); tick();
    op_alu(6, 3, 3); tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd0) begin n_errors++; $display("FAIL far_a: got %0d want 0", fwd_a_sel_o); end
    n_checks++; if (fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL far_b: got %0d want 0", fwd_b_sel_o); end
  endtask

  task automatic test_load_use();
    int base_cnt;
    drain();
    base_cnt = stall_total;
    op_lw(2, 29); tick();
    op_alu(4, 2, 1); #1;
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %0b want 1", stall_o); end
    tick(); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL lu_one_cycle: got %0b want 0", stall_o); end
    n_checks++; if (fwd_a_sel_o !== 2'd0) begin n_errors++; $display("FAIL lu_bubble_a: got %0d want 0", fwd_a_sel_o); end
    tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd2) begin n_errors++; $display("FAIL lu_fwd_a: got %0d want 2", fwd_a_sel_o); end
    n_checks++; if (fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL lu_fwd_b: got %0d want 0", fwd_b_sel_o); end
    n_checks++; if (stall_cnt_o !== 16'(base_cnt + 1)) begin n_errors++; $display("FAIL lu_cnt1: got %0d want %0d", stall_cnt_o, base_cnt + 1); end

    drain();
    op_lw(2, 29); tick();
    op_lw(2, 29); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL b2b_lw_nostall: got %0b want 0", stall_o); end
    tick();
    op_alu(4, 2, 1); #1;
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL b2b_stall: got %0b want 1", stall_o); end
    tick(); tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd2) begin n_errors++; $display("FAIL b2b_fwd_a: got %0d want 2", fwd_a_sel_o); end
    n_checks++; if (stall_cnt_o !== 16'(base_cnt + 2)) begin n_errors++; $display("FAIL b2b_cnt2: got %0d want %0d", stall_cnt_o, base_cnt + 2); end
  endtask

  task automatic test_zero_flush();
    int base_cnt;
    drain();
    op_lw(0, 29); tick();
    op_alu(4, 0, 0); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL r0_nostall: got %0b want 0", stall_o); end
    tick();
    op_nop(); #1;
    n_checks++; if (fwd_a_sel_o !== 2'd0) begin n_errors++; $display("FAIL r0_a: got %0d want 0", fwd_a_sel_o); end
    n_checks++; if (fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL r0_b: got %0d want 0", fwd_b_sel_o); end

    drain();
    base_cnt = stall_total;
    op_lw(2, 29); tick();
    drive(1, 2, 1, 1, 1, 4, 1, 0, 1); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL flush_nostall: got %0b want 0", stall_o); end
    tick();
    op_alu(8, 4, 4); tick();
    op_nop(); #1;
    // A flushed add to $4 in MEM would otherwise forward with select 1.
    n_checks++; if (fwd_a_sel_o !== 2'd0) begin n_errors++; $display("FAIL flush_bubble_a: got %0d want 0", fwd_a_sel_o); end
    n_checks++; if (stall_cnt_o !== 16'(base_cnt)) begin n_errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt_o, base_cnt); end
  endtask

  task automatic test_saturation();
    rst_i = 1'b1; op_nop(); tick();
    rst_i = 1'b0;
    // lw $2,0($2) repeatedly: each one depends on its predecessor, stalling every other cycle.
    op_lw(2, 2);
    for (int c = 0; c < 40; c++) begin
      #1;
      n_checks++; if (stall_o !== exp_stall()) begin n_errors++; $display("FAIL sat_stall c%0d: got %0b want %0b", c, stall_o, exp_stall()); end
      tick();
      n_checks++; if (sat_cnt !== 4'(sat_to(stall_total, 15))) begin n_errors++; $display("FAIL sat_cnt c%0d: got %0d want %0d", c, sat_cnt, sat_to(stall_total, 15)); end
    end
    n_checks++; if (stall_cnt_o !== 16'd20) begin n_errors++; $display("FAIL sat_wide_cnt: got %0d want 20", stall_cnt_o); end
    n_checks++; if (sat_cnt !== 4'hF) begin n_errors++; $display("FAIL sat_hold: got %0d want 15", sat_cnt); end
  endtask

  task automatic test_mid_reset();
    drain();
    op_lw(2, 29); tick();
    op_alu(4, 2, 1); #1;
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_stall: got %0b want 1", stall_o); end
    rst_i = 1'b1;
    tick(); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL midrst_stall: got %0b want 0", stall_o); end
    n_checks++; if (stall_cnt_o !== 16'd0) begin n_errors++; $display("FAIL midrst_cnt: got %0d want 0", stall_cnt_o); end
    n_checks++; if (sat_cnt !== 4'd0) begin n_errors++; $display("FAIL midrst_sat_cnt: got %0d want 0", sat_cnt); end
    n_checks++; if (fwd_a_sel_o !== 2'd0 || fwd_b_sel_o !== 2'd0) begin n_errors++; $display("FAIL midrst_sel: got %0d/%0d want 0/0", fwd_a_sel_o, fwd_b_sel_o); end
    rst_i = 1'b0;
    op_nop(); tick();
  endtask

  task automatic test_random();
    bit hold = 0;
    int ea, eb;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 0);
      end
      flush_i = ($urandom_range(0, 9) == 0);
      rst_i   = ($urandom_range(0, 199) == 0);
      #1;
      ea = exp_sel(hist[0].rs, hist[0].rs_used);
      eb = exp_sel(hist[0].rt, hist[0].rt_used);
      n_checks++; if (fwd_a_sel_o !== 2'(ea)) begin n_errors++; $display("FAIL rnd_a c%0d: got %0d want %0d", c, fwd_a_sel_o, ea); end
      n_checks++; if (fwd_b_sel_o !== 2'(eb)) begin n_errors++; $display("FAIL rnd_b c%0d: got %0d want %0d", c, fwd_b_sel_o, eb); end
      n_checks++; if (stall_o !== exp_stall()) begin n_errors++; $display("FAIL rnd_stall c%0d: got %0b want %0b", c, stall_o, exp_stall()); end
      n_checks++; if (stall_cnt_o !== 16'(sat_to(stall_total, 65535))) begin n_errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cnt_o, stall_total); end
      n_checks++; if (sat_cnt !== 4'(sat_to(stall_total, 15))) begin n_errors++; $display("FAIL rnd_sat_cnt c%0d: got %0d want %0d", c, sat_cnt, sat_to(stall_total, 15)); end
      hold = exp_stall();
      tick();
    end
    rst_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    stall_total = 0;
    hist[0] = BUBBLE; hist[1] = BUBBLE; hist[2] = BUBBLE;
    test_reset();
    test_ex_fwd();
    test_mem_wb();
    test_load_use();
    test_zero_flush();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
